// File: rtl/dec_pkg.sv
// Shared definitions for the decryption-core stream loader: word and block
// geometry, the core timeout limit and the loader state encoding.
package dec_pkg;

  localparam int WORD_W    = 9;
  localparam int BLK_WORDS = 4;
  localparam int KEY_WORDS = 16;
  localparam int BLK_W     = WORD_W * BLK_WORDS;  // 36
  localparam int KEY_W     = WORD_W * KEY_WORDS;  // 144
  localparam int TIMEOUT   = 255;
  localparam int TMO_W     = 8;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_LOAD_KEY = 3'd1,
    ST_LOAD_BLK = 3'd2,
    ST_RUN      = 3'd3,
    ST_HOLD_OUT = 3'd4
  } state_e;

  // States in which the loader takes words from the input stream.
  function automatic logic accepts_words(input state_e s);
    return (s == ST_IDLE) || (s == ST_LOAD_KEY) || (s == ST_LOAD_BLK);
  endfunction

endpackage

// File: rtl/dec_stream_loader_word_packer.sv
// MSB-first word packer: the n-th pushed word lands in slot n counted from the
// top of data_o. last_o is the full flag seen from the write side: it is high
// while the next push completes the set, after which the count wraps to zero.
// clear_i rewinds the count but keeps the packed contents.
module word_packer #(
  parameter int WORD_W = 9,
  parameter int WORDS  = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clear_i,
  input  logic                    push_i,
  input  logic [WORD_W-1:0]       data_i,
  output logic [WORD_W*WORDS-1:0] data_o,
  output logic                    last_o
);

  localparam int CNT_W = (WORDS > 1) ? $clog2(WORDS) : 1;

  logic [CNT_W-1:0]        count_q, count_d;
  logic [WORD_W*WORDS-1:0] data_q, data_d;

  assign last_o = (count_q == CNT_W'(WORDS - 1));
  assign data_o = data_q;

  // Next count and next packed contents from clear/push.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can leave a latch.
    count_d = count_q;
    data_d  = data_q;
    if (clear_i) begin
      count_d = '0;
    end else if (push_i) begin
      count_d = last_o ? '0 : count_q + CNT_W'(1);
      for (int i = 0; i < WORDS; i++) begin
        if (count_q == CNT_W'(i)) begin
          data_d[(WORDS-1-i)*WORD_W +: WORD_W] = data_i;
        end
      end
    end
  end

  // Count and packed data registers.
  always_ff @(posedge clk) begin
    // NOTE: sequential state is assigned with <= only, so every register samples pre-edge values.
    if (rst) begin
      count_q <= '0;
      // NOTE: the packed word store is cleared on reset because it drives key/blk outputs that must read zero.
      data_q  <= '0;
    end else begin
      count_q <= count_d;
      data_q  <= data_d;
    end
  end

endmodule

// File: rtl/dec_stream_loader.sv
// Stream loader for the 36-bit decryption core: packs key and ciphertext
// words, drives the core start level, captures the result and hands it to a
// valid/ready consumer. Flags stream protocol violations and core timeouts.
module dec_stream_loader
  import dec_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] in_data,
  input  logic              in_is_key,
  output logic [KEY_W-1:0]  key,
  output logic              key_valid,
  output logic [BLK_W-1:0]  blk,
  output logic              start,
  input  logic              dec_done,
  input  logic [BLK_W-1:0]  dec_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [BLK_W-1:0]  out_data,
  output logic              err_proto,
  output logic              err_tmo
);

  state_e           state_q, state_d;
  logic             key_valid_q, key_valid_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic [BLK_W-1:0] out_data_q;
  logic             err_proto_q, err_proto_d;
  logic             err_tmo_q, err_tmo_d;

  logic xfer;
  logic done_ok;
  logic capture;
  logic key_push, key_clear, key_last;
  logic blk_push, blk_clear, blk_last;

  assign xfer    = in_valid && in_ready;
  // The first RUN cycle (count 0) ignores done left over from the previous block.
  assign done_ok = dec_done && (tmo_q != '0);

  word_packer #(.WORD_W(WORD_W), .WORDS(KEY_WORDS)) u_key_packer (
    .clk     (clk),
    .rst     (rst),
    .clear_i (key_clear),
    .push_i  (key_push),
    .data_i  (in_data),
    .data_o  (key),
    .last_o  (key_last)
  );

  word_packer #(.WORD_W(WORD_W), .WORDS(BLK_WORDS)) u_blk_packer (
    .clk     (clk),
    .rst     (rst),
    .clear_i (blk_clear),
    .push_i  (blk_push),
    .data_i  (in_data),
    .data_o  (blk),
    .last_o  (blk_last)
  );

  // Next-state, packer control, error pulses and timeout count.
  always_comb begin
    state_d     = state_q;
    key_valid_d = key_valid_q;
    err_proto_d = 1'b0;
    err_tmo_d   = 1'b0;
    capture     = 1'b0;
    key_push    = 1'b0;
    key_clear   = 1'b0;
    blk_push    = 1'b0;
    blk_clear   = 1'b0;
    tmo_d       = (state_q == ST_RUN) ? tmo_q + TMO_W'(1) : '0;

    case (state_q)
      ST_IDLE: begin
        if (xfer) begin
          if (in_is_key) begin
            key_push    = 1'b1;
            key_valid_d = 1'b0;
            state_d     = ST_LOAD_KEY;
          end else if (key_valid_q) begin
            blk_push = 1'b1;
            state_d  = ST_LOAD_BLK;
          end else begin
            err_proto_d = 1'b1;
          end
        end
      end
      ST_LOAD_KEY: begin
        if (xfer) begin
          if (in_is_key) begin
            key_push = 1'b1;
            if (key_last) begin
              key_valid_d = 1'b1;
              state_d     = ST_IDLE;
            end
          end else begin
            key_clear   = 1'b1;
            key_valid_d = 1'b0;
            err_proto_d = 1'b1;
            state_d     = ST_IDLE;
          end
        end
      end
      ST_LOAD_BLK: begin
        if (xfer) begin
          if (!in_is_key) begin
            blk_push = 1'b1;
            if (blk_last) begin
              state_d = ST_RUN;
            end
          end else begin
            blk_clear   = 1'b1;
            err_proto_d = 1'b1;
            state_d     = ST_IDLE;
          end
        end
      end
      ST_RUN: begin
        // Done takes priority over a timeout in the same cycle.
        if (done_ok) begin
          capture = 1'b1;
          state_d = ST_HOLD_OUT;
        end else if (tmo_q == TMO_W'(TIMEOUT)) begin
          err_tmo_d = 1'b1;
          state_d   = ST_IDLE;
        end
      end
      ST_HOLD_OUT: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, key status, timeout counter, result and error registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      key_valid_q <= 1'b0;
      tmo_q       <= '0;
      out_data_q  <= '0;
      err_proto_q <= 1'b0;
      err_tmo_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      key_valid_q <= key_valid_d;
      tmo_q       <= tmo_d;
      err_proto_q <= err_proto_d;
      err_tmo_q   <= err_tmo_d;
      if (capture) begin
        out_data_q <= dec_data;
      end
    end
  end

  assign in_ready  = !rst && accepts_words(state_q);
  assign start     = (state_q == ST_RUN);
  assign out_valid = (state_q == ST_HOLD_OUT);
  assign key_valid = key_valid_q;
  assign out_data  = out_data_q;
  assign err_proto = err_proto_q;
  assign err_tmo   = err_tmo_q;

endmodule

// File: tb/tb_dec_stream_loader.sv
// Directed bench for dec_stream_loader with a behavioural core model and a
// result scoreboard.
module tb_dec_stream_loader;

  localparam int CORE_NORMAL = 0;  // done 12 cycles into start
  localparam int CORE_SILENT = 1;  // never responds
  localparam int CORE_STUCK  = 2;  // done stuck high

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [8:0]   in_data;
  logic         in_is_key;
  logic [143:0] key;
  logic         key_valid;
  logic [35:0]  blk;
  logic         start;
  logic         dec_done = 1'b0;
  logic [35:0]  dec_data;
  logic         out_valid;
  logic         out_ready;
  logic [35:0]  out_data;
  logic         err_proto;
  logic         err_tmo;

  int           checks   = 0;
  int           failures = 0;
  logic [35:0]  exp_q[$];
  logic [143:0] exp_key;
  logic [35:0]  core_data = 36'h0;
  int           core_mode = CORE_NORMAL;
  int           core_cnt  = 0;

  always #5 clk = ~clk;

  dec_stream_loader dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_is_key (in_is_key),
    .key       (key),
    .key_valid (key_valid),
    .blk       (blk),
    .start     (start),
    .dec_done  (dec_done),
    .dec_data  (dec_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .err_proto (err_proto),
    .err_tmo   (err_tmo)
  );

  // Core model: counts negedges with start high, raises done on the 12th.
  always @(negedge clk) begin
    if (start === 1'b1) core_cnt = core_cnt + 1;
    else                core_cnt = 0;
    case (core_mode)
      CORE_NORMAL: dec_done = (start === 1'b1) && (core_cnt >= 12);
      CORE_STUCK:  dec_done = 1'b1;
      default:     dec_done = 1'b0;
    endcase
  end
  // Result bus carries garbage whenever done is low.
  assign dec_data = dec_done ? core_data : ~core_data;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [143:0] obs, input logic [143:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_key"},       key,               144'h0);
    check({tag, "_key_valid"}, 144'(key_valid),   144'h0);
    check({tag, "_blk"},       144'(blk),         144'h0);
    check({tag, "_start"},     144'(start),       144'h0);
    check({tag, "_out_valid"}, 144'(out_valid),   144'h0);
    check({tag, "_out_data"},  144'(out_data),    144'h0);
    check({tag, "_err_proto"}, 144'(err_proto),   144'h0);
    check({tag, "_err_tmo"},   144'(err_tmo),     144'h0);
    check({tag, "_in_ready"},  144'(in_ready),    144'h1);
  endtask

  // Called at a negedge; presents one word for exactly one rising edge.
  task automatic send_word(input logic [8:0] d, input logic k);
    check("in_ready_before_word", 144'(in_ready), 144'h1);
    in_valid  = 1'b1;
    in_data   = d;
    in_is_key = k;
    @(negedge clk);
    in_valid  = 1'b0;
  endtask

  task automatic send_key(input int base);
    exp_key = '0;
    for (int i = 0; i < 16; i++) exp_key = {exp_key[134:0], 9'(base + i)};
    for (int i = 0; i < 15; i++) send_word(9'(base + i), 1'b1);
    check("key_valid_before_last_word", 144'(key_valid), 144'h0);
    send_word(9'(base + 15), 1'b1);
    check("key_valid_after_load", 144'(key_valid), 144'h1);
    check("key_value", key, exp_key);
  endtask

  task automatic send_block(input logic [35:0] b);
    for (int i = 0; i < 4; i++) begin
      send_word(b[35-9*i -: 9], 1'b0);
      if (i == 2) check("start_low_before_4th_word", 144'(start), 144'h0);
    end
    check("blk_value", 144'(blk), 144'(b));
    check("start_after_4th_word", 144'(start), 144'h1);
  endtask

  // Waits (bounded) for out_valid, compares with the scoreboard, optionally
  // stalls the consumer for 'hold' cycles, then completes the handshake.
  task automatic collect(input string tag, input int hold, output int lat);
    logic [35:0] exp;
    lat = 0;
    while (out_valid !== 1'b1 && lat < 400) begin
      @(negedge clk);
      lat++;
    end
    check({tag, "_out_valid"}, 144'(out_valid), 144'h1);
    check({tag, "_sb_nonempty"}, 144'(exp_q.size() > 0), 144'h1);
    if (out_valid === 1'b1 && exp_q.size() > 0) begin
      exp = exp_q.pop_front();
      check({tag, "_out_data"}, 144'(out_data), 144'(exp));
      check({tag, "_start_low"}, 144'(start), 144'h0);
      for (int i = 0; i < hold; i++) begin
        @(negedge clk);
        check({tag, "_hold_valid"},    144'(out_valid), 144'h1);
        check({tag, "_hold_data"},     144'(out_data),  144'(exp));
        check({tag, "_hold_in_ready"}, 144'(in_ready),  144'h0);
        check({tag, "_hold_start"},    144'(start),     144'h0);
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      check({tag, "_valid_dropped"}, 144'(out_valid), 144'h0);
      check({tag, "_in_ready_back"}, 144'(in_ready),  144'h1);
    end
  endtask

  initial begin
    int lat;
    logic saw_valid;

    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_is_key = 1'b0;
    out_ready = 1'b0;

    // Reset.
    repeat (3) @(negedge clk);
    check("in_ready_during_reset", 144'(in_ready), 144'h0);
    rst = 1'b0;
    #1;
    check_all_zero("reset");

    // Ciphertext word with no key loaded.
    send_word(9'h1AA, 1'b0);
    check("nokey_err_proto", 144'(err_proto), 144'h1);
    check("nokey_blk_dropped", 144'(blk), 144'h0);
    check("nokey_stay_idle", 144'(in_ready), 144'h1);
    @(negedge clk);
    check("nokey_err_pulse_end", 144'(err_proto), 144'h0);

    // Key 0x001..0x010, then the reference block.
    send_key(1);
    core_mode = CORE_NORMAL;
    core_data = 36'h123456789;
    exp_q.push_back(36'h123456789);
    send_block({9'h1AA, 9'h055, 9'h0F0, 9'h10F});
    collect("blk1", 5, lat);
    check("blk1_latency", 144'(lat), 144'd12);

    // Key word as 3rd block word aborts the block and rewinds its count.
    send_word(9'h011, 1'b0);
    send_word(9'h022, 1'b0);
    send_word(9'h033, 1'b1);
    check("blkabort_err_proto", 144'(err_proto), 144'h1);
    check("blkabort_key_valid", 144'(key_valid), 144'h1);
    check("blkabort_key_kept", key, exp_key);
    check("blkabort_start", 144'(start), 144'h0);
    core_data = 36'hA5A5A5A5A;
    exp_q.push_back(36'hA5A5A5A5A);
    send_block({9'h0C1, 9'h0C2, 9'h0C3, 9'h0C4});
    collect("blk2", 0, lat);

    // Two back-to-back blocks on the same key.
    core_data = 36'hABCDEF012;
    exp_q.push_back(36'hABCDEF012);
    send_block({9'h101, 9'h102, 9'h103, 9'h104});
    collect("b2b_a", 0, lat);
    core_data = 36'h0FEDCBA98;
    exp_q.push_back(36'h0FEDCBA98);
    send_block({9'h1F1, 9'h0E2, 9'h1D3, 9'h0C4});
    collect("b2b_b", 0, lat);
    check("b2b_key_unchanged", key, exp_key);
    check("b2b_key_valid", 144'(key_valid), 144'h1);

    // Done stuck high at RUN entry: ignored in the first RUN cycle.
    core_mode = CORE_STUCK;
    core_data = 36'h0F0F0F0F0;
    exp_q.push_back(36'h0F0F0F0F0);
    send_block({9'h011, 9'h012, 9'h013, 9'h014});
    check("stuck_no_valid_entry", 144'(out_valid), 144'h0);
    @(negedge clk);
    check("stuck_ignored_cycle1_start", 144'(start), 144'h1);
    check("stuck_ignored_cycle1_valid", 144'(out_valid), 144'h0);
    collect("stuck", 0, lat);
    check("stuck_latency", 144'(lat), 144'd1);
    core_mode = CORE_NORMAL;

    // Core never answers: timeout after counter reaches 255.
    core_mode = CORE_SILENT;
    send_block({9'h021, 9'h022, 9'h023, 9'h024});
    lat = 0;
    saw_valid = 1'b0;
    while (err_tmo !== 1'b1 && lat < 400) begin
      @(negedge clk);
      lat++;
      if (out_valid === 1'b1) saw_valid = 1'b1;
    end
    check("tmo_latency", 144'(lat), 144'd256);
    check("tmo_start_low", 144'(start), 144'h0);
    check("tmo_no_out_valid", 144'(saw_valid), 144'h0);
    check("tmo_back_idle", 144'(in_ready), 144'h1);
    check("tmo_key_valid_kept", 144'(key_valid), 144'h1);
    @(negedge clk);
    check("tmo_pulse_end", 144'(err_tmo), 144'h0);

    // Reset in the middle of RUN, then a full reload.
    send_block({9'h031, 9'h032, 9'h033, 9'h034});
    repeat (5) @(negedge clk);
    check("midrun_start_before_reset", 144'(start), 144'h1);
    rst = 1'b1;
    #1;
    check("midrun_in_ready_in_reset", 144'(in_ready), 144'h0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_all_zero("midrun_reset");
    core_mode = CORE_NORMAL;
    send_key(9'h040);
    core_data = 36'h314159265;
    exp_q.push_back(36'h314159265);
    send_block({9'h0AA, 9'h0BB, 9'h0CC, 9'h0DD});
    collect("after_run_reset", 0, lat);

    // Reset while the 9th key word is presented, then a full reload.
    for (int i = 0; i < 8; i++) send_word(9'(9'h1E0 + i), 1'b1);
    in_valid  = 1'b1;
    in_data   = 9'h1E8;
    in_is_key = 1'b1;
    rst       = 1'b1;
    @(negedge clk);
    rst      = 1'b0;
    in_valid = 1'b0;
    #1;
    check_all_zero("midkey_reset");
    send_key(9'h100);
    core_data = 36'h271828182;
    exp_q.push_back(36'h271828182);
    send_block({9'h1A1, 9'h1B2, 9'h1C3, 9'h1D4});
    collect("after_key_reset", 0, lat);
    check("final_key", key, exp_key);

    check("scoreboard_empty", 144'(exp_q.size()), 144'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
